// File: rtl/nes_rom_load_arb.sv
// nes_rom_load_arb
//   Arbitrates the NES PRG/CHR RAMs between the external ROM programmer and the
//   running NES. Each rising edge of a programmer strobe produces exactly one
//   RAM write. The first write moves the block from RUN to LOAD. Loading ends
//   after IDLE_TIMEOUT quiet cycles. The NES is then held for a further
//   SETTLE_CYCLES, and load_done pulses when it is released.
//
//   Optional build macro: ROM_LOAD_CHECKSUM_EN builds the additive checksum of
//   written bytes. Without it, checksum is tied to zero.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   prg_wren, chr_wren    programmer write strobes (level)
//   prgmr_addr/data       programmer byte address / data
//   cpu_addr, ppu_addr    NES read addresses, passed through in RUN
//   prg_mem_*, chr_mem_*  RAM address / write data / write enable
//   nes_hold              holds the NES in reset during LOAD and SETTLE
//   loading               high in LOAD
//   load_done             one-cycle pulse on release of the NES
//   prg_count, chr_count  saturating byte counts for the current load
//   checksum              modulo-256 sum of bytes written in the current load
module nes_rom_load_arb #(
  parameter int IDLE_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        prg_wren,
  input  logic        chr_wren,
  input  logic [15:0] prgmr_addr,
  input  logic [7:0]  prgmr_data,
  input  logic [14:0] cpu_addr,
  input  logic [12:0] ppu_addr,
  output logic [14:0] prg_mem_addr,
  output logic [7:0]  prg_mem_wdata,
  output logic        prg_mem_we,
  output logic [12:0] chr_mem_addr,
  output logic [7:0]  chr_mem_wdata,
  output logic        chr_mem_we,
  output logic        nes_hold,
  output logic        loading,
  output logic        load_done,
  output logic [15:0] prg_count,
  output logic [15:0] chr_count,
  output logic [7:0]  checksum
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic [15:0] QUIET_LAST  = 16'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef ROM_LOAD_CHECKSUM_EN
  function automatic logic [7:0] csum_add(input logic [7:0] base,
                                          input logic [7:0] data,
                                          input logic       add_prg,
                                          input logic       add_chr);
    logic [7:0] sum;
    sum = base;
    if (add_prg) sum = sum + data;
    if (add_chr) sum = sum + data;
    return sum;
  endfunction
`endif

  logic [1:0]  state, state_n;
  logic        prg_wren_p0, chr_wren_p0;
  logic        armed;
  logic        prg_edge, chr_edge, any_edge;
  logic [15:0] quiet_cnt, quiet_n;
  logic [7:0]  settle_cnt, settle_n;
  logic        done_n;
  logic        load_done_r;
  logic        prg_we_p0, chr_we_p0;
  logic [14:0] prg_waddr_p0;
  logic [12:0] chr_waddr_p0;
  logic [7:0]  prg_wdata_p0, chr_wdata_p0;
  logic [15:0] prg_cnt, chr_cnt;
  logic [15:0] prg_cnt_base, chr_cnt_base;
  logic        clr_counts;
  logic        unused_addr_msb;

  // The top programmer address bit does not select either RAM.
  assign unused_addr_msb = prgmr_addr[15];

  // A strobe already high when reset is released must not look like a rising
  // edge. The first cycle after reset therefore only captures the strobe level.
  assign prg_edge = armed & prg_wren & ~prg_wren_p0;
  assign chr_edge = armed & chr_wren & ~chr_wren_p0;
  assign any_edge = prg_edge | chr_edge;

  // A new load starts from RUN and restarts the counts before this edge's write.
  assign clr_counts   = any_edge && (state == ST_RUN);
  assign prg_cnt_base = clr_counts ? 16'd0 : prg_cnt;
  assign chr_cnt_base = clr_counts ? 16'd0 : chr_cnt;

  always_comb begin
    state_n  = state;
    quiet_n  = quiet_cnt;
    settle_n = settle_cnt;
    done_n   = 1'b0;
    case (state)
      ST_RUN: begin
        if (any_edge) begin
          state_n  = ST_LOAD;
          quiet_n  = 16'd0;
          settle_n = 8'd0;
        end
      end
      ST_LOAD: begin
        if (any_edge) begin
          quiet_n = 16'd0;
        end else if (quiet_cnt == QUIET_LAST) begin
          state_n  = ST_SETTLE;
          settle_n = 8'd0;
        end else begin
          quiet_n = quiet_cnt + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (any_edge) begin
          state_n = ST_LOAD;
          quiet_n = 16'd0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_n = ST_RUN;
          done_n  = 1'b1;
        end else begin
          settle_n = settle_cnt + 8'd1;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  // Stage p0: edge detect -> registered RAM write, state and counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_RUN;
      prg_wren_p0 <= 1'b0;
      chr_wren_p0 <= 1'b0;
      armed       <= 1'b0;
      quiet_cnt   <= 16'd0;
      settle_cnt  <= 8'd0;
      load_done_r <= 1'b0;
      prg_we_p0   <= 1'b0;
      chr_we_p0   <= 1'b0;
      prg_cnt     <= 16'd0;
      chr_cnt     <= 16'd0;
    end else begin
      state       <= state_n;
      prg_wren_p0 <= prg_wren;
      chr_wren_p0 <= chr_wren;
      armed       <= 1'b1;
      quiet_cnt   <= quiet_n;
      settle_cnt  <= settle_n;
      load_done_r <= done_n;
      prg_we_p0   <= prg_edge;
      chr_we_p0   <= chr_edge;
      if (any_edge) begin
        prg_cnt <= prg_edge ? sat_inc(prg_cnt_base) : prg_cnt_base;
        chr_cnt <= chr_edge ? sat_inc(chr_cnt_base) : chr_cnt_base;
      end
    end
  end

  // Write address/data are only observed while the matching we is high, so
  // they need no reset.
  always_ff @(posedge Clk) begin
    if (prg_edge) begin
      prg_waddr_p0 <= prgmr_addr[14:0];
      prg_wdata_p0 <= prgmr_data;
    end
    if (chr_edge) begin
      chr_waddr_p0 <= prgmr_addr[12:0];
      chr_wdata_p0 <= prgmr_data;
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      csum <= 8'd0;
    end else if (any_edge) begin
      csum <= csum_add(clr_counts ? 8'd0 : csum, prgmr_data, prg_edge, chr_edge);
    end
  end

  assign checksum = csum;
`else
  assign checksum = 8'd0;
`endif

  // A pending write owns the RAM port. Otherwise the NES reads in RUN, and the
  // address is parked at zero while the NES is held.
  assign prg_mem_we    = prg_we_p0;
  assign prg_mem_wdata = prg_wdata_p0;
  assign prg_mem_addr  = prg_we_p0 ? prg_waddr_p0 :
                         (state == ST_RUN) ? cpu_addr : 15'd0;
  assign chr_mem_we    = chr_we_p0;
  assign chr_mem_wdata = chr_wdata_p0;
  assign chr_mem_addr  = chr_we_p0 ? chr_waddr_p0 :
                         (state == ST_RUN) ? ppu_addr : 13'd0;

  assign nes_hold  = (state != ST_RUN);
  assign loading   = (state == ST_LOAD);
  assign load_done = load_done_r;
  assign prg_count = prg_cnt;
  assign chr_count = chr_cnt;

endmodule
